// File: rtl/pending_prio_encoder.sv
// rtl/pending_prio_encoder.sv - sticky pending set issuing one index per valid/ready handshake.
// Define PENDING_PRIO_ROUND_ROBIN_EN for rotating priority instead of fixed highest-index-first.
module pending_prio_encoder #(
   parameter int N = 8,
   parameter int W = $clog2(N)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] req,
   input  logic         out_ready,
   output logic [W-1:0] out_idx,
   output logic         out_valid,
   output logic [N-1:0] pending,
   output logic         busy,
   output logic         coalesced
);

   logic         take;
   logic         load;
   logic [N-1:0] src;
   logic [N-1:0] sel_mask;
   logic [W-1:0] sel;

   always_comb begin
      take     = out_valid & out_ready;
      load     = !out_valid | take;
      src      = pending | req;
      sel_mask = N'(1) << sel;
      busy     = (|pending) | out_valid;
   end

`ifdef PENDING_PRIO_ROUND_ROBIN_EN
   logic [W-1:0] last_idx;
   logic [W-1:0] eff_last;
   logic [W-1:0] cand;
   logic         found;
   int           c;

   // The index being accepted this cycle already counts as the most recent grant.
   always_comb begin
      eff_last = take ? out_idx : last_idx;
      sel      = '0;
      cand     = '0;
      found    = 1'b0;
      c        = 0;
      for (int i = 1; i <= N; i++) begin
         c    = (int'(eff_last) + N - i) % N;
         cand = W'(c);
         if (!found && src[cand]) begin
            sel   = cand;
            found = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_idx <= '0;
      end else if (take) begin
         last_idx <= out_idx;
      end
   end
`else
   always_comb begin
      sel = '0;
      for (int i = 0; i < N; i++) begin
         if (src[i]) begin
            sel = W'(i);
         end
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         pending   <= '0;
         out_valid <= 1'b0;
         out_idx   <= '0;
         coalesced <= 1'b0;
      end else begin
         // Re-requesting the in-flight index is not a merge; only the registered set counts.
         coalesced <= |(req & pending);
         if (load) begin
            if (|src) begin
               out_idx   <= sel;
               out_valid <= 1'b1;
               pending   <= src & ~sel_mask;
            end else begin
               out_valid <= 1'b0;
               pending   <= '0;
            end
         end else begin
            pending <= src;
         end
      end
   end

endmodule

// File: doc/pending_prio_encoder.md
Name: pending_prio_encoder

Overview:
- Parametrised, registered successor to the 4:2 priority encoder with valid flag.
- Captures N single-cycle or level request lines into a sticky pending set.
- Issues pending indices one at a time on a valid/ready output port, highest index first.
- Sits between interrupt/event sources and a single consumer that services one index per handshake.

Parameters:
- N, 8, number of request lines (N >= 2).
- W, $clog2(N), index width (derived; do not override).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- req  input  N  request bits; bit k high in a cycle marks index k pending.
- out_ready  input  1  consumer accepts out_idx this cycle.
- out_idx  output  W  index being issued.
- out_valid  output  1  out_idx is valid.
- pending  output  N  registered pending set, excluding the in-flight index.
- busy  output  1  |pending OR out_valid (combinational from registers).
- coalesced  output  1  one-cycle pulse: a req bit hit an index already pending.

Behaviour:
- Reset (rst high at clk edge): pending=0, out_valid=0, out_idx=0, coalesced=0. req is ignored in that cycle. Reset mid-handshake drops the in-flight index and all pending indices.
- take = out_valid & out_ready.
- load = !out_valid | take.
- src = pending | req.
- sel is the highest set index of src (fixed priority: N-1 highest, 0 lowest).
- On each edge with rst low:
  - If load and src != 0: out_idx<=sel, out_valid<=1, pending<=src & ~(1<<sel).
  - If load and src == 0: out_valid<=0, out_idx holds, pending<=0.
  - If !load: out_idx and out_valid hold, pending<=src.
- Latency: req bit k high in cycle t with an idle output gives out_valid=1, out_idx=k from cycle t+1.
- Back-to-back issue: with take every cycle, one index is issued per cycle, no bubbles.
- Handshake rules: out_idx is stable while out_valid=1 and out_ready=0. A lower index never pre-empts an unaccepted issue, even if a higher req arrives; the higher req waits in pending.
- Coalescing:
  - req bit k while pending[k]=1 merges into the existing entry (serviced once).
  - coalesced<=1 for one cycle if (req & pending) != 0.
- In-flight re-request: req[k] while out_valid=1 and out_idx=k sets pending[k]. Index k is issued again after the current one is accepted. This is not counted as coalesced.
- Simultaneous take and new req: a new req takes part in the same-cycle selection via src.
- out_ready while out_valid=0 has no effect.

Optional Feature:
- Macro: PENDING_PRIO_ROUND_ROBIN_EN.
- Defined: rotating priority. A register last_idx (reset 0) updates to out_idx on each take. The search starts at last_idx-1, descends, and wraps from 0 to N-1. last_idx itself has lowest priority. With a single pending index, that index is selected regardless of last_idx.
- Undefined: fixed highest-index priority as above; no last_idx register.

Test Plan:
- Reset/idle: rst=1 for 2 cycles with req=8'hFF -> after release, out_valid=0, pending=0, busy=0, coalesced=0.
- Priority and order: N=8, req=8'b1000_0101 for one cycle, out_ready=1 -> out_idx 7, 2, 0 in cycles t+1, t+2, t+3; out_valid=0 at t+4.
- Backpressure: req=8'h10 then 8'h80 with out_ready=0 -> out_idx stays 4 with out_valid held and pending=8'h80; raising out_ready gives 4 then 7.
- Coalesce: out_ready=0, req[3] at t, then req=8'h0A at t+1 while index 3 is in flight and pending=8'h00 -> pending=8'h0A, coalesced=0. Repeat req[1] at t+2 -> coalesced=1 for exactly one cycle.
- Mid-operation reset: pending=8'h3C with out_valid=1, assert rst for one cycle -> next cycle everything is cleared; no stale index is reissued.
- Round-robin (macro defined): req held at 8'h81, out_ready=1 -> out_idx alternates 7, 0, 7, 0. Without the macro -> 7 repeatedly (re-request after each take).
